// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bus bundle between the execute/memory result producers,
// the issue logic and the writeback arbiter.
//   alu_*  : ALU result (always accepted, no ready)
//   mem_*  : load result with valid/ready handshake
//   fpu_*  : FPU result with valid/ready handshake
//   iss_*  : issue-side scoreboard query, iss_stall answer
//   w_*    : registered write port towards regf
// slave  = the arbiter side, master = the producers/issue/regf side.
interface wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;

  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;

  logic        fpu_valid;
  logic        fpu_ready;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_data;

  logic        iss_valid;
  logic [4:0]  iss_rs1;
  logic        iss_rs1_used;
  logic [4:0]  iss_rs2;
  logic        iss_rs2_used;
  logic [4:0]  iss_rd;
  logic        iss_stall;

  logic        w_enable;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  fpu_valid, fpu_rd, fpu_data,
    output fpu_ready,
    input  iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used, iss_rd,
    output iss_stall,
    output w_enable, w_addr, w_data
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output fpu_valid, fpu_rd, fpu_data,
    input  fpu_ready,
    output iss_valid, iss_rs1, iss_rs1_used, iss_rs2, iss_rs2_used, iss_rd,
    input  iss_stall,
    input  w_enable, w_addr, w_data
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU, load and FPU results into one registered regf
// write per cycle and keeps the destination-register busy scoreboard.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : wb_arbiter_if.slave (producer handshakes, issue query, write port)
// ALU has fixed top priority. MEM beats FPU unless the FPU has been refused
// for STARVE_MAX consecutive valid cycles.
module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rstn,
  wb_arbiter_if.slave  bus
);

  localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic [31:0] busy;
  logic [31:0] busy_next;

  logic        fpu_pri;
  logic        grant_alu, grant_mem, grant_fpu, grant;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  logic        win_wr;
  logic        iss_take;

  always_comb begin
    fpu_pri   = bus.fpu_valid && (starve_cnt >= STARVE_TH);
    grant_alu = bus.alu_valid;
    grant_mem = 1'b0;
    grant_fpu = 1'b0;
    if (!bus.alu_valid) begin
      if (fpu_pri)            grant_fpu = 1'b1;
      else if (bus.mem_valid) grant_mem = 1'b1;
      else if (bus.fpu_valid) grant_fpu = 1'b1;
    end
  end

  assign grant = grant_alu || grant_mem || grant_fpu;

  always_comb begin
    win_rd   = bus.fpu_rd;
    win_data = bus.fpu_data;
    if (grant_alu) begin
      win_rd   = bus.alu_rd;
      win_data = bus.alu_data;
    end else if (grant_mem) begin
      win_rd   = bus.mem_rd;
      win_data = bus.mem_data;
    end
  end

  assign win_wr = grant && (win_rd != 5'd0);

  // Readies are forced low while reset is asserted so nothing handshakes
  // into a register that is being cleared.
  assign bus.mem_ready = rstn && grant_mem;
  assign bus.fpu_ready = rstn && grant_fpu;

  // busy[0] is held at zero, so x0 never stalls.
  assign bus.iss_stall = bus.iss_valid &&
                         ((bus.iss_rs1_used && busy[bus.iss_rs1]) ||
                          (bus.iss_rs2_used && busy[bus.iss_rs2]) ||
                          ((bus.iss_rd != 5'd0) && busy[bus.iss_rd]));

  assign iss_take = bus.iss_valid && !bus.iss_stall && (bus.iss_rd != 5'd0);

  // Clear first, then set: a new producer issued on the writeback edge of
  // the old one keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (win_wr)   busy_next[win_rd]     = 1'b0;
    if (iss_take) busy_next[bus.iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.w_enable <= 1'b0;
      bus.w_addr   <= 5'd0;
      bus.w_data   <= 32'd0;
    end else begin
      bus.w_enable <= win_wr;
      if (grant) begin
        bus.w_addr <= win_rd;
        bus.w_data <= win_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= 4'd0;
    end else if (!bus.fpu_valid || grant_fpu) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic clk;
  logic rstn;
  int   tests;
  int   fails;

  wb_arbiter_if bus ();

  wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.mem_valid = 1'b0; bus.mem_rd = 5'd0; bus.mem_data = 32'd0;
    bus.fpu_valid = 1'b0; bus.fpu_rd = 5'd0; bus.fpu_data = 32'd0;
    bus.iss_valid = 1'b0; bus.iss_rs1 = 5'd0; bus.iss_rs1_used = 1'b0;
    bus.iss_rs2 = 5'd0; bus.iss_rs2_used = 1'b0; bus.iss_rd = 5'd0;
  endtask

  task automatic chk_ready(input string tag, input logic m, input logic f);
    chk({tag, "_mem_ready"}, 32'(bus.mem_ready), 32'(m));
    chk({tag, "_fpu_ready"}, 32'(bus.fpu_ready), 32'(f));
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_w_enable"}, 32'(bus.w_enable), 32'(en));
    chk({tag, "_w_addr"},   32'(bus.w_addr),   32'(a));
    chk({tag, "_w_data"},   bus.w_data,        d);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle_all();

    // Reset with every source valid.
    rstn = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h0000_00A5;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd8; bus.mem_data = 32'h0000_0088;
    bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd7; bus.fpu_data = 32'h0000_0077;
    repeat (2) tick();
    chk_wr("rst", 1'b0, 5'd0, 32'd0);
    chk_ready("rst", 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk_ready("rel", 1'b0, 1'b0);
    tick();
    chk_wr("rel_alu", 1'b1, 5'd9, 32'h0000_00A5);
    idle_all();

    // Scoreboard set then ALU writeback clears it.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5;
    #1;
    chk("iss5_nostall", 32'(bus.iss_stall), 32'd0);
    tick();
    chk_wr("idle_after_alu", 1'b0, 5'd9, 32'h0000_00A5);
    bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd5; bus.iss_rs1_used = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
    #1;
    chk("rs1_5_stall", 32'(bus.iss_stall), 32'd1);
    tick();
    chk_wr("alu5", 1'b1, 5'd5, 32'hDEAD_BEEF);
    bus.alu_valid = 1'b0;
    #1;
    chk("rs1_5_free", 32'(bus.iss_stall), 32'd0);
    idle_all();

    // All three valid: ALU, then MEM, then FPU.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 32'h22;
    bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd3; bus.fpu_data = 32'h33;
    #1;
    chk_ready("all_c0", 1'b0, 1'b0);
    tick();
    chk_wr("all_alu", 1'b1, 5'd1, 32'h11);
    bus.alu_valid = 1'b0;
    #1;
    chk_ready("all_c1", 1'b1, 1'b0);
    tick();
    chk_wr("all_mem", 1'b1, 5'd2, 32'h22);
    bus.mem_valid = 1'b0;
    #1;
    chk_ready("all_c2", 1'b0, 1'b1);
    tick();
    chk_wr("all_fpu", 1'b1, 5'd3, 32'h33);
    bus.fpu_valid = 1'b0;
    tick();
    chk_wr("all_idle", 1'b0, 5'd3, 32'h33);

    // Starvation: FPU refused 4 cycles, wins the 5th.
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h44;
    bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd6; bus.fpu_data = 32'h66;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_ready($sformatf("starve%0d", i), 1'b1, 1'b0);
      tick();
    end
    #1;
    chk_ready("starve_win", 1'b0, 1'b1);
    tick();
    chk_wr("starve_fpu", 1'b1, 5'd6, 32'h66);
    bus.fpu_rd = 5'd12; bus.fpu_data = 32'h6666;
    #1;
    chk_ready("starve_cleared", 1'b1, 1'b0);
    tick();
    chk_wr("starve_mem_again", 1'b1, 5'd4, 32'h44);
    idle_all();

    // Load to x0: handshake completes, no write enable.
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd0; bus.mem_data = 32'h1234;
    #1;
    chk_ready("x0", 1'b1, 1'b0);
    tick();
    chk_wr("x0_wr", 1'b0, 5'd0, 32'h1234);
    idle_all();
    bus.iss_valid = 1'b1; bus.iss_rs1 = 5'd0; bus.iss_rs1_used = 1'b1;
    bus.iss_rs2 = 5'd4; bus.iss_rs2_used = 1'b1;
    #1;
    chk("x0_nobusy", 32'(bus.iss_stall), 32'd0);
    idle_all();

    // Set and clear of rd=7 on one edge: set wins.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7777;
    #1;
    chk("same7_issue_ok", 32'(bus.iss_stall), 32'd0);
    tick();
    chk_wr("same7_wr", 1'b1, 5'd7, 32'h7777);
    idle_all();
    bus.iss_valid = 1'b1; bus.iss_rs2 = 5'd7; bus.iss_rs2_used = 1'b1;
    #1;
    chk("rs2_7_stall", 32'(bus.iss_stall), 32'd1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7070;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    chk("rs2_7_free", 32'(bus.iss_stall), 32'd0);
    idle_all();

    // Async reset mid-handshake.
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd10;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'hBB;
    tick();
    chk_wr("pre_rst_wr", 1'b1, 5'd11, 32'hBB);
    bus.iss_rd = 5'd0; bus.iss_rs1 = 5'd10; bus.iss_rs1_used = 1'b1;
    bus.fpu_valid = 1'b1; bus.fpu_rd = 5'd13; bus.fpu_data = 32'hCC;
    #1;
    chk("pre_rst_busy10", 32'(bus.iss_stall), 32'd1);
    chk_ready("pre_rst", 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk_wr("async_rst", 1'b0, 5'd0, 32'd0);
    chk_ready("async_rst", 1'b0, 1'b0);
    chk("async_rst_busy", 32'(bus.iss_stall), 32'd0);
    bus.alu_valid = 1'b0;
    #1;
    chk_ready("rst_fpu_only", 1'b0, 1'b0);
    tick();
    chk_wr("rst_hold", 1'b0, 5'd0, 32'd0);
    idle_all();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk_wr("post_rst_idle", 1'b0, 5'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
